// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: producer-side and consumer-side handshake bundle for rr_mux_n.
interface rr_mux_n_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int S = $clog2(N);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [S-1:0]   out_sel;
   logic           out_valid;
   logic           out_ready;
   modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_sel, out_valid);
   modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_sel, out_valid);
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel arbitrated mux (round-robin or fixed priority) into a one-entry output register.
module rr_mux_n #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int ARB_MODE = 0,
   localparam int S       = $clog2(N)
) (
   input logic        clk,
   input logic        rst_n,
   rr_mux_n_if.slave  bus
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t         state, state_nxt;
   logic [S-1:0]   ptr, win_sel;
   logic [N-1:0]   grant, hi, lo_mask;
   logic [W-1:0]   win_data;
   logic           can_load, accept;

   function automatic logic [N-1:0] lsb(input logic [N-1:0] x);
      return x & (~x + N'(1));
   endfunction

   // Requests at or above ptr win first; otherwise wrap to the lowest requester.
   assign lo_mask  = (N'(1) << ptr) - N'(1);
   assign hi       = bus.in_valid & ~lo_mask;
   assign grant    = (ARB_MODE == 1 || hi == '0) ? lsb(bus.in_valid) : lsb(hi);
   assign can_load = state == EMPTY || bus.out_ready;
   assign bus.in_ready = grant & {N{can_load & rst_n}};
   assign accept   = |bus.in_ready;
   assign bus.out_valid = state == FULL;

   always_comb begin
      win_sel  = '0;
      win_data = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) begin
            win_sel  = S'(i);
            win_data = bus.in_data[i*W +: W];
         end
   end

   always_comb begin
      state_nxt = accept ? FULL : bus.out_ready ? EMPTY : state;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else state <= state_nxt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.out_data <= '0;
         bus.out_sel  <= '0;
         ptr          <= '0;
      end else if (accept) begin
         bus.out_data <= win_data;
         bus.out_sel  <= win_sel;
         if (ARB_MODE == 0) ptr <= (win_sel == S'(N-1)) ? '0 : win_sel + 1'b1;
      end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed checks of round-robin (N=4, N=3) and fixed-priority (N=4) muxes.
module tb_rr_mux_n;
   logic clk = 0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   rr_mux_n_if #(.N(4), .W(8)) a ();
   rr_mux_n_if #(.N(3), .W(8)) b ();
   rr_mux_n_if #(.N(4), .W(8)) c ();

   rr_mux_n #(.N(4), .W(8), .ARB_MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   rr_mux_n #(.N(3), .W(8), .ARB_MODE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
   rr_mux_n #(.N(4), .W(8), .ARB_MODE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0;
      a.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      b.in_data = {8'hB2, 8'hB1, 8'hB0};
      c.in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      a.in_valid = 4'hF; b.in_valid = 3'h7; c.in_valid = 4'b0101;
      a.out_ready = 0; b.out_ready = 0; c.out_ready = 0;
      repeat (2) tick();
      check("rst_valid", a.out_valid, 0);
      check("rst_sel", a.out_sel, 0);
      check("rst_data", a.out_data, 0);
      check("rst_inready", a.in_ready, 0);
      check("rst_inready_c", c.in_ready, 0);
      rst_n = 1;
      a.out_ready = 1; b.out_ready = 1; c.out_ready = 1;
      #1;
      check("first_grant_a", a.in_ready, 4'b0001);
      check("first_grant_b", b.in_ready, 3'b001);
      check("first_grant_c", c.in_ready, 4'b0001);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("rr_valid_a", a.out_valid, 1);
         check("rr_sel_a", a.out_sel, i % 4);
         check("rr_data_a", a.out_data, 8'hA0 + i % 4);
         check("rr_sel_b", b.out_sel, i % 3);
         check("rr_data_b", b.out_data, 8'hB0 + i % 3);
         check("fp_sel_c", c.out_sel, 0);
         check("fp_inready_c", c.in_ready, 4'b0001);
      end
      a.out_ready = 0;
      #1;
      check("stall_inready0", a.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_sel", a.out_sel, 2);
         check("stall_data", a.out_data, 8'hA2);
         check("stall_valid", a.out_valid, 1);
         check("stall_inready", a.in_ready, 0);
      end
      a.out_ready = 1;
      #1;
      check("unstall_grant", a.in_ready, 4'b1000);
      tick();
      check("unstall_sel", a.out_sel, 3);
      check("unstall_data", a.out_data, 8'hA3);
      tick();
      check("wrap_sel0", a.out_sel, 0);
      tick();
      check("wrap_sel1", a.out_sel, 1);
      a.in_valid = 4'b1010;
      c.in_valid = 4'b0100;
      #1;
      check("sparse_grant3", a.in_ready, 4'b1000);
      check("fp_drop_c", c.in_ready, 4'b0100);
      tick();
      check("sparse_sel3", a.out_sel, 3);
      check("sparse_ptr0", a.in_ready, 4'b0010);
      check("fp_sel2_c", c.out_sel, 2);
      tick();
      check("sparse_sel1", a.out_sel, 1);
      check("sparse_data1", a.out_data, 8'hA1);
      check("sparse_ptr2", a.in_ready, 4'b1000);
      a.in_valid = 0;
      tick();
      check("drain_empty", a.out_valid, 0);
      a.in_valid = 4'b0100;
      a.out_ready = 0;
      #1;
      check("empty_load_grant", a.in_ready, 4'b0100);
      tick();
      check("pre_rst_valid", a.out_valid, 1);
      check("pre_rst_sel", a.out_sel, 2);
      #2 rst_n = 0;
      #1;
      check("async_rst_valid", a.out_valid, 0);
      check("async_rst_sel", a.out_sel, 0);
      check("async_rst_data", a.out_data, 0);
      check("async_rst_inready", a.in_ready, 0);
      #1 rst_n = 1;
      a.in_valid = 4'b1010;
      a.out_ready = 1;
      #1;
      check("post_rst_ptr0", a.in_ready, 4'b0010);
      tick();
      check("post_rst_sel", a.out_sel, 1);
      check("post_rst_data", a.out_data, 8'hA1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
